// File: rtl/mips_decode_exec_unit.sv
// mips_decode_exec_unit
//   Main opcode decoder, ALU-control decoder and 32-bit ALU for the five-stage
//   MIPS core, together with the ID/EX and EX/MEM pipeline registers around
//   the ALU.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   stall                 load-use stall: EX control bubble, EX data holds
//   flush                 branch/jump flush: clears all EX registers
//   opcode, seimm         ID instruction[31:26] and sign-extended immediate
//   data1, data2          ID rs / rt operands
//   regdst .. jump, aluop ID control bundle, combinational from opcode
//   aluctl, alurslt, zero EX ALU control, result and zero flag (combinational)
//   alurslt_s4, zero_s4   MEM registered result / zero flag
//   regwrite_s4, memtoreg_s4, memread_s4, memwrite_s4  MEM registered controls
module mips_decode_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] seimm,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             regdst,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrc,
  output logic             jump,
  output logic [1:0]       aluop,
  output logic [3:0]       aluctl,
  output logic [WIDTH-1:0] alurslt,
  output logic             zero,
  output logic [WIDTH-1:0] alurslt_s4,
  output logic             zero_s4,
  output logic             regwrite_s4,
  output logic             memtoreg_s4,
  output logic             memread_s4,
  output logic             memwrite_s4
);

  // EX-stage registers (ID/EX)
  logic             r_ex_memread;
  logic             r_ex_memwrite;
  logic             r_ex_memtoreg;
  logic             r_ex_regwrite;
  logic             r_ex_alusrc;
  logic [1:0]       r_ex_aluop;
  logic [WIDTH-1:0] r_ex_seimm;
  logic [WIDTH-1:0] r_ex_data1;
  logic [WIDTH-1:0] r_ex_data2;

  // MEM-stage registers (EX/MEM)
  logic [WIDTH-1:0] r_mem_alurslt;
  logic             r_mem_zero;
  logic             r_mem_regwrite;
  logic             r_mem_memtoreg;
  logic             r_mem_memread;
  logic             r_mem_memwrite;

  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic [5:0]       w_funct;
  logic             w_ctl_bubble;

  // ---------------------------------------------------------------- ID decode
  always_comb begin
    regdst    = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    alusrc    = 1'b0;
    jump      = 1'b0;
    aluop     = 2'b00;
    unique case (opcode)
      6'b000000: begin regdst = 1'b1; regwrite = 1'b1; aluop = 2'b10; end
      6'b100011: begin memread = 1'b1; memtoreg = 1'b1; alusrc = 1'b1; regwrite = 1'b1; end
      6'b101011: begin memwrite = 1'b1; alusrc = 1'b1; end
      6'b000100: begin branch_eq = 1'b1; aluop = 2'b01; end
      6'b000101: begin branch_ne = 1'b1; aluop = 2'b01; end
      6'b001000: begin alusrc = 1'b1; regwrite = 1'b1; end
      6'b000010: jump = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------------------ ID/EX register
  // EX regdst has no consumer inside this block (destination select is done
  // outside), so it is not stored here.
  assign w_ctl_bubble = stall | flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_memread  <= 1'b0;
      r_ex_memwrite <= 1'b0;
      r_ex_memtoreg <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_alusrc   <= 1'b0;
      r_ex_aluop    <= 2'b00;
    end else if (w_ctl_bubble) begin
      r_ex_memread  <= 1'b0;
      r_ex_memwrite <= 1'b0;
      r_ex_memtoreg <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_alusrc   <= 1'b0;
      r_ex_aluop    <= 2'b00;
    end else begin
      r_ex_memread  <= memread;
      r_ex_memwrite <= memwrite;
      r_ex_memtoreg <= memtoreg;
      r_ex_regwrite <= regwrite;
      r_ex_alusrc   <= alusrc;
      r_ex_aluop    <= aluop;
    end
  end

  // Flush takes priority over stall for the operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_seimm <= '0;
      r_ex_data1 <= '0;
      r_ex_data2 <= '0;
    end else if (flush) begin
      r_ex_seimm <= '0;
      r_ex_data1 <= '0;
      r_ex_data2 <= '0;
    end else if (!stall) begin
      r_ex_seimm <= seimm;
      r_ex_data1 <= data1;
      r_ex_data2 <= data2;
    end
  end

  // ------------------------------------------------------------ ALU control
  assign w_funct = r_ex_seimm[5:0];

  always_comb begin
    aluctl = 4'b0000;
    unique case (r_ex_aluop)
      2'b00: aluctl = 4'b0010;
      2'b01: aluctl = 4'b0110;
      2'b10: begin
        unique case (w_funct)
          6'b100000: aluctl = 4'b0010;
          6'b100010: aluctl = 4'b0110;
          6'b100100: aluctl = 4'b0000;
          6'b100101: aluctl = 4'b0001;
          6'b101010: aluctl = 4'b0111;
          6'b100111: aluctl = 4'b1100;
          default:   aluctl = 4'b0000;
        endcase
      end
      default: aluctl = 4'b0000;
    endcase
  end

  // ------------------------------------------------------------------- ALU
  assign w_alu_a = r_ex_data1;
  assign w_alu_b = r_ex_alusrc ? r_ex_seimm : r_ex_data2;

  always_comb begin
    alurslt = '0;
    unique case (aluctl)
      4'b0000: alurslt = w_alu_a & w_alu_b;
      4'b0001: alurslt = w_alu_a | w_alu_b;
      4'b0010: alurslt = w_alu_a + w_alu_b;
      4'b0110: alurslt = w_alu_a - w_alu_b;
      4'b0111: alurslt = {{(WIDTH-1){1'b0}}, ($signed(w_alu_a) < $signed(w_alu_b))};
      4'b1100: alurslt = ~(w_alu_a | w_alu_b);
      default: alurslt = '0;
    endcase
  end

  assign zero = (alurslt == '0);

  // ----------------------------------------------------------- EX/MEM register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_alurslt  <= '0;
      r_mem_zero     <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_memtoreg <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_mem_memwrite <= 1'b0;
    end else begin
      r_mem_alurslt  <= alurslt;
      r_mem_zero     <= zero;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memtoreg <= r_ex_memtoreg;
      r_mem_memread  <= r_ex_memread;
      r_mem_memwrite <= r_ex_memwrite;
    end
  end

  assign alurslt_s4  = r_mem_alurslt;
  assign zero_s4     = r_mem_zero;
  assign regwrite_s4 = r_mem_regwrite;
  assign memtoreg_s4 = r_mem_memtoreg;
  assign memread_s4  = r_mem_memread;
  assign memwrite_s4 = r_mem_memwrite;

endmodule

// File: tb/tb_mips_decode_exec_unit.sv
// tb_mips_decode_exec_unit
//   Directed-vector bench for mips_decode_exec_unit with hand-computed
//   expected values for the ID decode, EX ALU and MEM registered outputs.
module tb_mips_decode_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [5:0]  opcode;
  logic [31:0] seimm;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        regdst, branch_eq, branch_ne, memread, memwrite;
  logic        memtoreg, regwrite, alusrc, jump;
  logic [1:0]  aluop;
  logic [3:0]  aluctl;
  logic [31:0] alurslt;
  logic        zero;
  logic [31:0] alurslt_s4;
  logic        zero_s4, regwrite_s4, memtoreg_s4, memread_s4, memwrite_s4;

  int unsigned n_checks;
  int unsigned n_errors;

  mips_decode_exec_unit #(.WIDTH(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .opcode      (opcode),
    .seimm       (seimm),
    .data1       (data1),
    .data2       (data2),
    .regdst      (regdst),
    .branch_eq   (branch_eq),
    .branch_ne   (branch_ne),
    .memread     (memread),
    .memwrite    (memwrite),
    .memtoreg    (memtoreg),
    .regwrite    (regwrite),
    .alusrc      (alusrc),
    .jump        (jump),
    .aluop       (aluop),
    .aluctl      (aluctl),
    .alurslt     (alurslt),
    .zero        (zero),
    .alurslt_s4  (alurslt_s4),
    .zero_s4     (zero_s4),
    .regwrite_s4 (regwrite_s4),
    .memtoreg_s4 (memtoreg_s4),
    .memread_s4  (memread_s4),
    .memwrite_s4 (memwrite_s4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b);
    opcode = op;
    seimm  = imm;
    data1  = a;
    data2  = b;
  endtask

  // {regdst,branch_eq,branch_ne,memread,memwrite,memtoreg,regwrite,alusrc,jump,aluop}
  function automatic logic [31:0] id_ctl();
    return {21'd0, regdst, branch_eq, branch_ne, memread, memwrite,
            memtoreg, regwrite, alusrc, jump, aluop};
  endfunction

  // {regwrite_s4,memtoreg_s4,memread_s4,memwrite_s4,zero_s4}
  function automatic logic [31:0] mem_ctl();
    return {27'd0, regwrite_s4, memtoreg_s4, memread_s4, memwrite_s4, zero_s4};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(6'b111111, 32'h0, 32'h0, 32'h0);

    // Reset asserted before any clock edge
    #2;
    check("rst_alurslt_s4", alurslt_s4, 32'h0);
    check("rst_memctl",     {28'd0, regwrite_s4, memtoreg_s4, memread_s4, memwrite_s4}, 32'h0);
    check("rst_aluctl",     {28'd0, aluctl}, 32'h2);
    check("rst_zero",       {31'd0, zero}, 32'h1);
    check("id_invalid",     id_ctl(), 32'h0);
    rst_n = 1'b1;

    tick();
    check("first_zero_s4",    {31'd0, zero_s4}, 32'h1);
    check("first_alurslt_s4", alurslt_s4, 32'h0);

    // C1: R add
    drive(6'b000000, 32'h20, 32'd5, 32'd7);
    #1 check("id_rtype", id_ctl(), {21'd0, 11'b1_0_0_0_0_0_1_0_0_10});
    tick();
    check("add_aluctl",  {28'd0, aluctl}, 32'h2);
    check("add_alurslt", alurslt, 32'd12);
    check("add_zero",    {31'd0, zero}, 32'h0);

    // C2: slt -1 < 1
    drive(6'b000000, 32'h2A, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("slt1_aluctl",  {28'd0, aluctl}, 32'h7);
    check("slt1_alurslt", alurslt, 32'd1);
    check("add_s4",       alurslt_s4, 32'd12);
    check("add_memctl",   mem_ctl(), 32'b10000);

    // C3: slt 1 < -1 is false
    drive(6'b000000, 32'h2A, 32'd1, 32'hFFFF_FFFF);
    tick();
    check("slt0_alurslt", alurslt, 32'd0);
    check("slt0_zero",    {31'd0, zero}, 32'h1);
    check("slt1_s4",      alurslt_s4, 32'd1);
    check("slt1_zero_s4", {31'd0, zero_s4}, 32'h0);

    // C4: lw
    drive(6'b100011, 32'd8, 32'd100, 32'h55);
    #1 check("id_lw", id_ctl(), {21'd0, 11'b0_0_0_1_0_1_1_1_0_00});
    tick();
    check("lw_alurslt",   alurslt, 32'd108);
    check("slt0_memctl",  mem_ctl(), 32'b10001);

    // C5: beq with equal operands
    drive(6'b000100, 32'h3, 32'd9, 32'd9);
    #1 check("id_beq", id_ctl(), {21'd0, 11'b0_1_0_0_0_0_0_0_0_01});
    tick();
    check("beq_aluctl", {28'd0, aluctl}, 32'h6);
    check("beq_zero",   {31'd0, zero}, 32'h1);
    check("lw_s4",      alurslt_s4, 32'd108);
    check("lw_memctl",  mem_ctl(), 32'b11100);

    // C6: sw
    drive(6'b101011, 32'd4, 32'd200, 32'hAB);
    #1 check("id_sw", id_ctl(), {21'd0, 11'b0_0_0_0_1_0_0_1_0_00});
    tick();
    check("sw_alurslt", alurslt, 32'd204);
    check("beq_memctl", mem_ctl(), 32'b00001);

    // C7: stall -- control bubble, operands 200/0xAB held, B now data2
    stall = 1'b1;
    drive(6'b000000, 32'h25, 32'hF0, 32'h0F);
    tick();
    check("stall_aluctl",  {28'd0, aluctl}, 32'h2);
    check("stall_alurslt", alurslt, 32'd371);
    check("sw_s4",         alurslt_s4, 32'd204);
    check("sw_memctl",     mem_ctl(), 32'b00010);

    // C8: stall together with flush -- flush wins
    flush = 1'b1;
    tick();
    check("sflush_alurslt", alurslt, 32'd0);
    check("sflush_zero",    {31'd0, zero}, 32'h1);
    check("stall_s4",       alurslt_s4, 32'd371);
    check("stall_memctl",   mem_ctl(), 32'b00000);
    stall = 1'b0;
    flush = 1'b0;

    // C9: R or
    tick();
    check("or_aluctl",  {28'd0, aluctl}, 32'h1);
    check("or_alurslt", alurslt, 32'hFF);

    // C10: R nor
    drive(6'b000000, 32'h27, 32'hF0F0_F0F0, 32'h0F0F_0F00);
    tick();
    check("nor_aluctl",  {28'd0, aluctl}, 32'hC);
    check("nor_alurslt", alurslt, 32'h0000_000F);
    check("or_s4",       alurslt_s4, 32'hFF);

    // C11: R and
    drive(6'b000000, 32'h24, 32'hFF00_FF00, 32'h0FF0_0FF0);
    tick();
    check("and_aluctl",  {28'd0, aluctl}, 32'h0);
    check("and_alurslt", alurslt, 32'h0F00_0F00);

    // C12: R sub wrapping negative
    drive(6'b000000, 32'h22, 32'd3, 32'd5);
    tick();
    check("sub_aluctl",  {28'd0, aluctl}, 32'h6);
    check("sub_alurslt", alurslt, 32'hFFFF_FFFE);

    // C13: addi 1 + (-1) wraps to zero
    drive(6'b001000, 32'hFFFF_FFFF, 32'd1, 32'd77);
    #1 check("id_addi", id_ctl(), {21'd0, 11'b0_0_0_0_0_0_1_1_0_00});
    tick();
    check("addi_alurslt", alurslt, 32'h0);
    check("addi_zero",    {31'd0, zero}, 32'h1);

    // C14: R with unknown funct falls back to AND
    drive(6'b000000, 32'h3F, 32'd6, 32'd3);
    tick();
    check("badfn_aluctl",  {28'd0, aluctl}, 32'h0);
    check("badfn_alurslt", alurslt, 32'd2);
    check("addi_zero_s4",  {31'd0, zero_s4}, 32'h1);

    // C15: j, bne decode
    drive(6'b000010, 32'h0, 32'd1, 32'd2);
    #1 check("id_j", id_ctl(), {21'd0, 11'b0_0_0_0_0_0_0_0_1_00});
    opcode = 6'b000101;
    #1 check("id_bne", id_ctl(), {21'd0, 11'b0_0_1_0_0_0_0_0_0_01});
    tick();
    check("bne_alurslt", alurslt, 32'hFFFF_FFFF);

    // C16: flush alone on a lw
    flush = 1'b1;
    drive(6'b100011, 32'd8, 32'd100, 32'h0);
    tick();
    check("flush_alurslt", alurslt, 32'h0);
    flush = 1'b0;
    tick();
    check("flush_memctl", mem_ctl(), 32'b00001);
    check("lw2_alurslt",  alurslt, 32'd108);
    tick();
    check("lw2_memctl", mem_ctl(), 32'b11100);

    // Asynchronous reset mid-stream, away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("arst_s4",     alurslt_s4, 32'h0);
    check("arst_memctl", mem_ctl(), 32'b00000);
    check("arst_alurslt", alurslt, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    check("resume_zero_s4", {31'd0, zero_s4}, 32'h1);
    check("resume_alurslt", alurslt, 32'd108);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
